// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions for the RX and TX paths.
//   DATA_BITS     : payload bits per 8N1 frame
//   rx_state_e    : receiver FSM state encoding
//   clks_per_bit  : clock cycles per bit period (integer divide)
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream from the UART receiver FIFO to its consumer.
//   rd_valid : head of FIFO is valid
//   rd_data  : head-of-FIFO byte (first-word fall-through)
//   rd_ready : consumer pops the head when rd_valid & rd_ready
// master = byte source (the receiver), slave = consumer.
interface uart_rx_fifo_if;
  import uart_rx_fifo_pkg::*;

  logic                 rd_valid;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_ready;

  modport master (
    output rd_valid,
    output rd_data,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    output rd_ready
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word fall-through FIFO, shared by the UART RX and TX paths.
//   clk_i, rst_ni : clock, async active-low reset (pointers only)
//   push_i        : write push_data_i (dropped when full unless popping too)
//   pop_i         : remove head (ignored when empty)
//   head_o        : head entry, forced to zero while empty
//   empty_o/full_o: status; level_o: occupancy 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  assign rd_en = pop_i & ~empty_o;
  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
  assign wr_en = push_i & (~full_o | rd_en);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_en) wptr_d = wptr_q + PtrW'(1);
    if (rd_en) rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[AddrW-1:0]] <= push_data_i;
  end

  // Storage is not reset, so mask the head while empty.
  assign head_o  = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];
  assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO with a valid/ready read port.
//   clk_50M   : system clock, rising edge
//   k_resetb  : async active-low reset
//   rxd       : serial input, asynchronous, idle high
//   rd        : valid/ready byte stream (master modport)
//   level     : FIFO occupancy 0..DEPTH
//   frame_err : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun   : one-cycle pulse, byte completed while FIFO full (byte dropped)
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clk_50M,
  input  logic                   k_resetb,
  input  logic                   rxd,
  uart_rx_fifo_if.master         rd,
  output logic [$clog2(DEPTH):0] level,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned IdxW       = $clog2(DATA_BITS);

  logic                 rxd_meta_q, rxd_s_q;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 expire, push, pop;
  logic                 fifo_empty, fifo_full;

  // A counter loaded with N expires N cycles later, giving an exact bit period.
  assign expire = (cnt_q == CntW'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        // Half-period load lands the following samples mid-bit.
        if (!rxd_s_q) begin
          state_d = StStart;
          cnt_d   = CntW'(ClksPerBit / 2);
        end
      end
      StStart: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (!rxd_s_q) begin
          state_d   = StData;
          cnt_d     = CntW'(ClksPerBit);
          bit_idx_d = '0;
        end else begin
          state_d = StIdle;  // start bit did not hold: glitch
        end
      end
      StData: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = CntW'(ClksPerBit);
          if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + IdxW'(1);
          end
        end
      end
      StStop: begin
        if (!expire) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rxd_s_q) begin
          push    = 1'b1;
          state_d = StIdle;
        end else begin
          frame_err_d = 1'b1;
          state_d     = StWaitIdle;
        end
      end
      StWaitIdle: begin
        // Hold off re-arming until the line returns high so a break reports once.
        if (rxd_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop       = rd.rd_ready & rd.rd_valid;
  assign overrun_d = push & fifo_full & ~pop;

  always_ff @(posedge clk_50M or negedge k_resetb) begin
    if (!k_resetb) begin
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_50M),
    .rst_ni      (k_resetb),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .head_o      (rd.rd_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .level_o     (level)
  );

  assign rd.rd_valid = ~fifo_empty;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo. BAUD is raised so one bit is
// 250 clocks; every glitch/break length stays well inside or beyond half a bit.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int unsigned CLK_HZ = 50000000;
  localparam int unsigned BAUD   = 200000;
  localparam int unsigned DEPTH  = 16;
  localparam int N        = 250;     // clocks per bit
  localparam int H        = N / 2;
  // Push edge follows the falling start edge by 2 (sync) + H + 9N clocks;
  // this is that offset measured from the start of the stop bit.
  localparam int PUSH_OFS = 2 + H;

  logic       clk_50M  = 1'b0;
  logic       k_resetb = 1'b0;
  logic       rxd      = 1'b1;
  logic [4:0] level;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo_if rd_if ();

  uart_rx_fifo #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_50M   (clk_50M),
    .k_resetb  (k_resetb),
    .rxd       (rxd),
    .rd        (rd_if),
    .level     (level),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk_50M) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  // One rd_ready pulse, sampled by a single rising edge.
  task automatic pop_one();
    @(negedge clk_50M);
    rd_if.rd_ready = 1'b1;
    @(negedge clk_50M);
    rd_if.rd_ready = 1'b0;
  endtask

  // Serialise one frame; optionally raise rd_ready across the push edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit pop_at_push,
                           output logic v_before, output logic v_after,
                           output logic [7:0] d_at_push);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge clk_50M);
    for (int i = 0; i < 9; i++) begin
      rxd = frame[i];
      idle(N);
    end
    rxd = frame[9];
    idle(PUSH_OFS);
    v_before  = rd_if.rd_valid;
    d_at_push = rd_if.rd_data;
    if (pop_at_push) rd_if.rd_ready = 1'b1;
    idle(1);
    v_after        = rd_if.rd_valid;
    rd_if.rd_ready = 1'b0;
    idle(N - PUSH_OFS - 1);
  endtask

  task automatic test_reset();
    k_resetb = 1'b0;
    idle(3);
    checks++; if (rd_if.rd_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rd_valid: got %b want 0", rd_if.rd_valid); end
    checks++; if (rd_if.rd_data !== 8'h00) begin errors++;
      $display("FAIL reset_rd_data: got %h want 00", rd_if.rd_data); end
    checks++; if (level !== 5'd0) begin errors++;
      $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++;
      $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", frame_err, overrun); end
    k_resetb = 1'b1;
    idle(5);
  endtask

  task automatic test_single_byte();
    logic vb, va; logic [7:0] d;
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h55, 1'b1, 1'b0, vb, va, d);
    idle(2);
    checks++; if (vb !== 1'b0 || va !== 1'b1) begin errors++;
      $display("FAIL single_latency: valid before/after push %b/%b want 0/1", vb, va); end
    checks++; if (rd_if.rd_data !== 8'h55) begin errors++;
      $display("FAIL single_data: got %h want 55", rd_if.rd_data); end
    checks++; if (level !== 5'd1) begin errors++;
      $display("FAIL single_level: got %0d want 1", level); end
    checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin errors++;
      $display("FAIL single_pulses: got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0); end
    pop_one();
    idle(2);
    checks++; if (level !== 5'd0) begin errors++;
      $display("FAIL single_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    rxd = 1'b0;
    idle(100);
    rxd = 1'b1;
    idle(300);
    checks++; if (dut.state_q !== StIdle) begin errors++;
      $display("FAIL glitch_state: got %0d want %0d", dut.state_q, StIdle); end
    checks++; if (level !== 5'd0 || rd_if.rd_valid !== 1'b0) begin errors++;
      $display("FAIL glitch_level: got level=%0d valid=%b want 0 0", level, rd_if.rd_valid); end
    checks++; if (fe_cnt - fe0 != 0) begin errors++;
      $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    logic vb, va; logic [7:0] d;
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'hA5, 1'b0, 1'b0, vb, va, d);
    idle(2000);
    rxd = 1'b1;
    idle(2 * N);
    checks++; if (fe_cnt - fe0 != 1) begin errors++;
      $display("FAIL break_frame_err: got %0d pulses want 1", fe_cnt - fe0); end
    checks++; if (level !== 5'd0) begin errors++;
      $display("FAIL break_level: got %0d want 0", level); end
    send_byte(8'h3C, 1'b1, 1'b0, vb, va, d);
    idle(2);
    checks++; if (rd_if.rd_data !== 8'h3C || level !== 5'd1) begin errors++;
      $display("FAIL break_recover: got data=%h level=%0d want 3c 1", rd_if.rd_data, level); end
    pop_one();
    idle(2);
  endtask

  task automatic test_overrun();
    logic vb, va; logic [7:0] d;
    int ov0;
    ov0 = ov_cnt;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i), 1'b1, 1'b0, vb, va, d);
      if (i == 15) begin
        idle(2);
        checks++; if (level !== 5'd16 || ov_cnt - ov0 != 0) begin errors++;
          $display("FAIL fill_16: got level=%0d ov=%0d want 16 0", level, ov_cnt - ov0); end
      end
    end
    idle(2);
    checks++; if (level !== 5'd16) begin errors++;
      $display("FAIL overrun_level: got %0d want 16", level); end
    checks++; if (ov_cnt - ov0 != 1) begin errors++;
      $display("FAIL overrun_pulse: got %0d pulses want 1", ov_cnt - ov0); end
    checks++; if (rd_if.rd_data !== 8'h00) begin errors++;
      $display("FAIL overrun_head: got %h want 00", rd_if.rd_data); end
  endtask

  task automatic test_full_push_pop();
    logic vb, va; logic [7:0] d;
    int ov0;
    ov0 = ov_cnt;
    send_byte(8'h77, 1'b1, 1'b1, vb, va, d);
    idle(2);
    checks++; if (ov_cnt - ov0 != 0) begin errors++;
      $display("FAIL pushpop_overrun: got %0d pulses want 0", ov_cnt - ov0); end
    checks++; if (level !== 5'd16) begin errors++;
      $display("FAIL pushpop_level: got %0d want 16", level); end
    checks++; if (d !== 8'h00 || vb !== 1'b1) begin errors++;
      $display("FAIL pushpop_popped: got %h valid=%b want 00 1", d, vb); end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'(i + 1) : 8'h77;
      @(negedge clk_50M);
      checks++; if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp) begin errors++;
        $display("FAIL drain_%0d: got valid=%b data=%h want 1 %h", i, rd_if.rd_valid,
                 rd_if.rd_data, exp); end
      pop_one();
    end
    idle(2);
    checks++; if (level !== 5'd0 || rd_if.rd_valid !== 1'b0) begin errors++;
      $display("FAIL drain_empty: got level=%0d valid=%b want 0 0", level, rd_if.rd_valid); end
    pop_one();
    idle(2);
    checks++; if (level !== 5'd0 || rd_if.rd_data !== 8'h00) begin errors++;
      $display("FAIL pop_empty: got level=%0d data=%h want 0 00", level, rd_if.rd_data); end
  endtask

  task automatic test_reset_mid_frame();
    logic vb, va; logic [7:0] d;
    logic [9:0] frame;
    int fe0;
    send_byte(8'h11, 1'b1, 1'b0, vb, va, d);
    send_byte(8'h22, 1'b1, 1'b0, vb, va, d);
    idle(2);
    checks++; if (level !== 5'd2) begin errors++;
      $display("FAIL midreset_queued: got %0d want 2", level); end
    frame = {1'b1, 8'hC3, 1'b0};
    @(negedge clk_50M);
    for (int i = 0; i < 5; i++) begin
      rxd = frame[i];
      idle(N);
    end
    rxd = frame[5];  // data bit 4
    idle(H);
    k_resetb = 1'b0;
    #1;
    checks++; if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 8'h00 || level !== 5'd0)
      begin errors++;
      $display("FAIL midreset_outputs: got valid=%b data=%h level=%0d want 0 00 0",
               rd_if.rd_valid, rd_if.rd_data, level); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0 || dut.state_q !== StIdle)
      begin errors++;
      $display("FAIL midreset_state: got fe=%b ov=%b state=%0d want 0 0 %0d",
               frame_err, overrun, dut.state_q, StIdle); end
    idle(N - H);
    for (int i = 6; i < 10; i++) begin
      rxd = frame[i];
      idle(N);
    end
    k_resetb = 1'b1;
    idle(N);
    fe0 = fe_cnt;
    send_byte(8'h81, 1'b1, 1'b0, vb, va, d);
    idle(2);
    checks++; if (rd_if.rd_data !== 8'h81 || level !== 5'd1) begin errors++;
      $display("FAIL midreset_recover: got data=%h level=%0d want 81 1", rd_if.rd_data, level); end
    checks++; if (fe_cnt - fe0 != 0) begin errors++;
      $display("FAIL midreset_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    test_reset();
    test_single_byte();
    test_glitch();
    test_break();
    test_overrun();
    test_full_push_pop();
    test_drain();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
